// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI master shift engine with configurable word width, SCLK divider, CPOL/CPHA and bit order.
// Optional build macro SPI_LOOPBACK_EN adds a loopback input that samples MOSI in place of MISO.
module spi_shift_engine #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 lsb_first,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 hold_cs,
  input  logic                 dc_in,
`ifdef SPI_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 ready,
  output logic                 done,
  output logic [WIDTH-1:0]     data_out,
  output logic                 clk_out,
  output logic                 cs_n,
  output logic                 dc_out,
  output logic                 serial_out,
  input  logic                 serial_in
);

  localparam int unsigned   EW         = $clog2(2*WIDTH+1);
  localparam logic [EW-1:0] LAST_EDGE  = EW'(2*WIDTH);
  localparam logic [EW-1:0] FIRST_EDGE = EW'(1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0]     rx_sr_q, rx_sr_d;
  logic                 lsb_q, lsb_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 hold_q, hold_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [EW-1:0]        edge_cnt_q, edge_cnt_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 clk_out_q, clk_out_d;
  logic                 cs_n_q, cs_n_d;
  logic                 dc_out_q, dc_out_d;
  logic                 serial_out_q, serial_out_d;

  logic                 hp_end;
  logic [EW-1:0]        edge_next;
  logic                 last_edge;
  logic                 sample_edge;
  logic                 miso;
  logic [WIDTH-1:0]     tx_next;

  assign hp_end      = (div_cnt_q == '0);
  assign edge_next   = edge_cnt_q + 1'b1;
  assign last_edge   = (edge_next == LAST_EDGE);
  // Odd edges are leading: cpha=0 samples on them, cpha=1 on the trailing (even) ones.
  assign sample_edge = edge_next[0] ^ cpha_q;

`ifdef SPI_LOOPBACK_EN
  assign miso = loopback ? serial_out_q : serial_in;
`else
  assign miso = serial_in;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)               state_d = LEAD;
      LEAD:    if (hp_end)              state_d = SHIFT;
      SHIFT:   if (hp_end && last_edge) state_d = TRAIL;
      TRAIL:   if (hp_end)              state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    lsb_d        = lsb_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    div_d        = div_q;
    hold_d       = hold_q;
    div_cnt_d    = div_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    done_d       = 1'b0;
    data_out_d   = data_out_q;
    clk_out_d    = clk_out_q;
    cs_n_d       = cs_n_q;
    dc_out_d     = dc_out_q;
    serial_out_d = serial_out_q;
    tx_next      = lsb_q ? {1'b0, tx_sr_q[WIDTH-1:1]} : {tx_sr_q[WIDTH-2:0], 1'b0};

    if (state_q != IDLE) begin
      div_cnt_d = hp_end ? div_q : div_cnt_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d      = data_in;
          lsb_d        = lsb_first;
          cpol_d       = cpol;
          cpha_d       = cpha;
          div_d        = clk_div;
          hold_d       = hold_cs;
          div_cnt_d    = clk_div;
          edge_cnt_d   = '0;
          cs_n_d       = 1'b0;
          dc_out_d     = dc_in;
          clk_out_d    = cpol;
          serial_out_d = lsb_first ? data_in[0] : data_in[WIDTH-1];
        end
      end
      SHIFT: begin
        if (hp_end) begin
          edge_cnt_d = edge_next;
          clk_out_d  = last_edge ? cpol_q : ~clk_out_q;
          if (sample_edge) begin
            rx_sr_d = lsb_q ? {miso, rx_sr_q[WIDTH-1:1]} : {rx_sr_q[WIDTH-2:0], miso};
          end else if (!last_edge && edge_next != FIRST_EDGE) begin
            // Edge 1 under cpha=1 re-drives bit 0, which is already on the pin.
            tx_sr_d      = tx_next;
            serial_out_d = lsb_q ? tx_next[0] : tx_next[WIDTH-1];
          end
        end
      end
      TRAIL: begin
        if (hp_end) begin
          done_d     = 1'b1;
          data_out_d = rx_sr_q;
          cs_n_d     = ~hold_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      lsb_q        <= 1'b0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      div_q        <= '0;
      hold_q       <= 1'b0;
      div_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      done_q       <= 1'b0;
      data_out_q   <= '0;
      clk_out_q    <= 1'b0;
      cs_n_q       <= 1'b1;
      dc_out_q     <= 1'b0;
      serial_out_q <= 1'b0;
    end else begin
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      lsb_q        <= lsb_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      div_q        <= div_d;
      hold_q       <= hold_d;
      div_cnt_q    <= div_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      done_q       <= done_d;
      data_out_q   <= data_out_d;
      clk_out_q    <= clk_out_d;
      cs_n_q       <= cs_n_d;
      dc_out_q     <= dc_out_d;
      serial_out_q <= serial_out_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign done       = done_q;
  assign data_out   = data_out_q;
  assign clk_out    = clk_out_q;
  assign cs_n       = cs_n_q;
  assign dc_out     = dc_out_q;
  assign serial_out = serial_out_q;

endmodule
